audio_i2s_tx: RTL and testbench
===============================

# audio_i2s_tx

Downstream consumer of the PSG's stereo output. It generates the I2S bit clock, word-select and serial data for an external audio DAC from `clk`. Once per audio frame it latches the 16-bit left/right samples and issues a one-cycle `next_sample` strobe, which starts the PSG's computation of the following sample. The strobe therefore also sets the system audio sample rate: clk / (64·BCK_HALF).

## Interface
Parameters:
- BCK_HALF, default 8: clk cycles per half bit-clock period. Legal range 2..255.
  - 25 MHz clk with BCK_HALF=8 gives 48.828 kHz.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. Asynchronous, active-high.
- left_in, input, 16: signed left sample from the PSG.
- right_in, input, 16: signed right sample from the PSG.
- mute, input, 1: when high at the latch point, the whole frame is transmitted as zeros.
- next_sample, output, 1: one-cycle strobe at each frame start.
- i2s_bck, output, 1: bit clock.
- i2s_lrck, output, 1: word select. 0 = left, 1 = right.
- i2s_data, output, 1: serial data, MSB first.

## Operation
- Half-period divider `div_cnt` counts 0..BCK_HALF-1. On wrap, the registered `i2s_bck` toggles.
- Slot counter `slot` is 5 bits (0..31) and advances on every bck falling toggle (bck 1→0).
  - It wraps from 31 to 0.
  - Reset value is 31, so the first falling edge enters slot 0.
- On the falling edge entering slot s:
  - `i2s_lrck` <= (s >= 16).
  - `i2s_data` <= bit (31 − (s−1)) of frame word W, with W = {L[15:0], R[15:0]}.
  - The data bit lags `i2s_lrck` by one bck (standard I2S).
  - For s = 0, `i2s_data` <= the LSB of the previous frame's R, i.e. the last pending bit.
- Latch on entering slot 0:
  - W <= mute ? 32'h0 : {left_in, right_in}.
  - `next_sample` is high for exactly that one clk cycle.
- Implementation note: a 32-bit shift register loaded at slot 0, plus a 1-bit pending register for the output, satisfies the above.
- Latency: a sample is latched at frame n and serialized during frame n. The PSG result triggered by the strobe at frame n is latched at frame n+1.
- Inputs are sampled only in the latch cycle. Changes at any other time have no effect on the current frame.
- The PSG needs ≤ ~100 clk cycles per sample. The minimum frame length is 128 clk cycles at BCK_HALF=2, so the PSG always completes before the next latch.

## Timing
- Reset values (async, immediate): i2s_bck=0, i2s_lrck=0, i2s_data=0, next_sample=0, div_cnt=0, slot=31, W=0, pending bit=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- bck high and low phases are each exactly BCK_HALF clk cycles. Frame period is exactly 64·BCK_HALF clk cycles.
- After rst deasserts:
  - The first bck rising toggle occurs on the BCK_HALF-th clk edge.
  - The first falling toggle occurs on the 2·BCK_HALF-th clk edge, with next_sample=1 and slot 0.
  - Subsequent strobes occur every 64·BCK_HALF edges.
- i2s_lrck and i2s_data change only on the same clk edge as bck 1→0, so they are stable at every bck rising edge.
- Reset mid-frame:
  - All state returns to reset values immediately and the partial frame is discarded.
  - No next_sample is issued until the post-reset slot-0 entry.
- Simultaneous mute change and latch: the mute value sampled on the latch edge governs the whole frame.

## Test plan
- Reset/idle, BCK_HALF=8:
  - During reset, all outputs are 0.
  - After release, the first next_sample pulse arrives at clk edge 16 after release, then every 512 edges.
  - The bck period measures 16 clk cycles with 50% duty.
- Bit pattern, left_in=16'h8001, right_in=16'h7FFE, held constant:
  - Sampling i2s_data on bck rising edges, slots 1..16 give 1000_0000_0000_0001.
  - Slots 17..31 plus slot 0 of the next frame give 0111_1111_1111_1110.
  - lrck=0 for slots 0..15 and 1 for slots 16..31.
- Latch isolation: change left_in to 16'hFFFF one clk after the next_sample pulse. The current frame still transmits 16'h8001; the next frame transmits 16'hFFFF.
- Mute:
  - With mute=1 at the latch and left/right=16'h5555, all 32 data bits of that frame are 0.
  - Slot 0 of the muted frame still carries the previous frame's R LSB.
  - Deasserting mute mid-frame has no effect until the next latch.
- Reset mid-frame: assert rst at slot 20 for 3 cycles.
  - Outputs are 0 immediately.
  - next_sample reappears exactly 2·BCK_HALF edges after release.
- Minimum divider, BCK_HALF=2, with the PSG attached:
  - next_sample spacing is 128 cycles.
  - PSG left_audio settles before each latch.
  - The transmitted word equals the PSG output from the previous strobe.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
// I2S transmitter for the PSG stereo output. Derives the bit clock from clk,
// latches one left/right pair per 32-slot frame and serialises it MSB first
// with the data bit lagging word-select by one bit clock. The frame-start
// strobe next_sample paces the PSG and therefore sets the audio sample rate
// (clk / (64 * BCK_HALF)).
`timescale 1ns/1ps
module audio_i2s_tx #(
   parameter int unsigned BCK_HALF = 8   // clk cycles per half bit-clock, 2..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic        mute,
   output logic        next_sample,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_data
);

   localparam logic [7:0] DIV_LAST = 8'(BCK_HALF - 1);

   logic [7:0]  div_q,   div_d;
   logic        bck_q,   bck_d;
   logic [4:0]  slot_q,  slot_d;
   logic [31:0] shift_q, shift_d;
   logic        lrck_q,  lrck_d;
   logic        data_q,  data_d;
   logic        ns_q,    ns_d;

   // Next-state: divider, bit clock, slot counter and serialiser.
   // The shift register is loaded with the frame word on slot-0 entry and
   // shifted once per slot 1..31, so after 31 shifts its MSB holds the old
   // R LSB, which is exactly the bit owed on the following slot 0.
   always_comb begin
      div_d   = div_q + 8'd1;
      bck_d   = bck_q;
      slot_d  = slot_q;
      shift_d = shift_q;
      lrck_d  = lrck_q;
      data_d  = data_q;
      ns_d    = 1'b0;
      if (div_q == DIV_LAST) begin
         div_d = 8'd0;
         bck_d = ~bck_q;
         if (bck_q) begin
            // falling bit-clock edge: enter the next slot
            slot_d = slot_q + 5'd1;
            lrck_d = slot_d[4];
            data_d = shift_q[31];
            if (slot_d == 5'd0) begin
               shift_d = mute ? 32'h0000_0000 : {left_in, right_in};
               ns_d    = 1'b1;
            end else begin
               shift_d = {shift_q[30:0], 1'b0};
            end
         end else begin
            slot_d = slot_q;
         end
      end else begin
         div_d = div_q + 8'd1;
      end
   end

   // State register with asynchronous reset; slot starts at 31 so the first
   // falling bit-clock edge enters slot 0 and issues the first strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= 8'd0;
         bck_q   <= 1'b0;
         slot_q  <= 5'd31;
         shift_q <= 32'h0000_0000;
         lrck_q  <= 1'b0;
         data_q  <= 1'b0;
         ns_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         bck_q   <= bck_d;
         slot_q  <= slot_d;
         shift_q <= shift_d;
         lrck_q  <= lrck_d;
         data_q  <= data_d;
         ns_q    <= ns_d;
      end
   end

   assign next_sample = ns_q;
   assign i2s_bck     = bck_q;
   assign i2s_lrck    = lrck_q;
   assign i2s_data    = data_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: a BCK_HALF=8 instance driven with
// directed vectors and a BCK_HALF=2 instance fed by a simple PSG stand-in.
// Both are compared every cycle against an arithmetic model derived from the
// clk edge count since reset release.
`timescale 1ns/1ps
module tb_audio_i2s_tx;

   localparam int H8 = 8;
   localparam int H2 = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] l8, r8, l2, r2;
   logic        mute8;
   logic        mute2 = 1'b0;
   logic        ns8, bck8, lrck8, data8;
   logic        ns2, bck2, lrck2, data2;

   int tests = 0;
   int fails = 0;
   int k8 = 0;
   int k2 = 0;
   logic [31:0] words8 [256];
   logic [31:0] words2 [256];
   logic [31:0] psg_val;

   always #5 clk = ~clk;

   audio_i2s_tx #(.BCK_HALF(H8)) u_dut8 (
      .clk(clk), .rst(rst), .left_in(l8), .right_in(r8), .mute(mute8),
      .next_sample(ns8), .i2s_bck(bck8), .i2s_lrck(lrck8), .i2s_data(data8));

   audio_i2s_tx #(.BCK_HALF(H2)) u_dut2 (
      .clk(clk), .rst(rst), .left_in(l2), .right_in(r2), .mute(mute2),
      .next_sample(ns2), .i2s_bck(bck2), .i2s_lrck(lrck2), .i2s_data(data2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A latch happens on the edge that completes a falling bck into slot 0.
   function automatic bit is_latch(input int k, input int h);
      return (k > 0) && (k % (2 * h) == 0) && (((k / (2 * h)) - 1) % 32 == 0);
   endfunction

   function automatic int frame_of(input int k, input int h);
      return ((k / (2 * h)) - 1) / 32;
   endfunction

   // Expected {next_sample, bck, lrck, data} after k clk edges since release.
   function automatic logic [3:0] model(input int k, input int h, input logic [31:0] cur_w,
                                       input logic [31:0] prev_w, input bit has_prev);
      int f, s;
      logic ns_e, bck_e, lr_e, d_e;
      f     = k / (2 * h);
      bck_e = ((k / h) % 2) == 1;
      ns_e  = 1'b0;
      lr_e  = 1'b0;
      d_e   = 1'b0;
      if (f > 0) begin
         s    = (f - 1) % 32;
         ns_e = (k % (2 * h) == 0) && (s == 0);
         lr_e = (s >= 16);
         if (s == 0) d_e = has_prev ? prev_w[0] : 1'b0;
         else        d_e = cur_w[32 - s];
      end
      return {ns_e, bck_e, lr_e, d_e};
   endfunction

   // Model time base and the words the DUTs must latch at each frame start.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k8 <= 0;
         k2 <= 0;
      end else begin
         k8 <= k8 + 1;
         k2 <= k2 + 1;
         if (is_latch(k8 + 1, H8)) words8[frame_of(k8 + 1, H8) % 256] <= mute8 ? 32'h0 : {l8, r8};
         if (is_latch(k2 + 1, H2)) words2[frame_of(k2 + 1, H2) % 256] <= {l2, r2};
      end
   end

   // Single compare process: every cycle, both instances against the model.
   int cyc = 0;
   int last2 = 0;
   bit have2 = 1'b0;
   always @(negedge clk) begin
      int m8, m2;
      logic [3:0] e8, e2;
      m8 = (k8 / (2 * H8) > 0) ? frame_of(k8, H8) : 0;
      m2 = (k2 / (2 * H2) > 0) ? frame_of(k2, H2) : 0;
      e8 = model(k8, H8, words8[m8 % 256], words8[(m8 + 255) % 256], m8 > 0);
      e2 = model(k2, H2, words2[m2 % 256], words2[(m2 + 255) % 256], m2 > 0);
      check("model8", {28'd0, ns8, bck8, lrck8, data8}, {28'd0, e8});
      check("model2", {28'd0, ns2, bck2, lrck2, data2}, {28'd0, e2});
      cyc++;
      if (rst) begin
         have2 = 1'b0;
      end else if (ns2) begin
         if (have2) check("ns_gap_h2", cyc - last2, 32'd128);
         have2 = 1'b1;
         last2 = cyc;
      end
   end

   // PSG stand-in: produces a new sample 60 clks after each strobe.
   initial begin
      psg_val = 32'h0;
      l2 = 16'h0;
      r2 = 16'h0;
      forever begin
         @(negedge clk);
         if (ns2 && !rst) begin
            repeat (60) @(negedge clk);
            psg_val = psg_val + 32'h1357_9BDF;
            l2 = psg_val[31:16];
            r2 = psg_val[15:0];
         end
      end
   end

   task automatic wait_rise();
      logic prev;
      bit ok;
      prev = bck8;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bck8 && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = bck8;
      end
      if (!ok) check("bck_rise_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_strobe();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (ns8) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("strobe_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_to_strobe(output int n);
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (ns8) break;
      end
   endtask

   // Sample data/lrck on bck rising edges; optionally consume slot 0 first.
   task automatic capture(input bit skip, output logic [31:0] w, output logic [31:0] lr,
                          output logic b0);
      w = 32'h0;
      lr = 32'h0;
      b0 = 1'b0;
      if (skip) begin
         wait_rise();
         b0 = data8;
      end
      for (int i = 0; i < 32; i++) begin
         wait_rise();
         w  = {w[30:0], data8};
         lr = {lr[30:0], lrck8};
      end
   endtask

   initial begin
      int n, hi, lo;
      logic [31:0] w, lr;
      logic b0;
      rst = 1'b1;
      l8 = 16'h8001;
      r8 = 16'h7FFE;
      mute8 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {24'd0, ns8, bck8, lrck8, data8, ns2, bck2, lrck2, data2}, 32'd0);
      rst = 1'b0;

      count_to_strobe(n);
      check("first_strobe_edge", n, 32'd16);
      count_to_strobe(n);
      check("strobe_gap", n, 32'd512);

      wait_rise();
      hi = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bck8) hi++;
         else break;
      end
      lo = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bck8) lo++;
         else break;
      end
      check("bck_high_cycles", hi, 32'd8);
      check("bck_low_cycles", lo, 32'd8);

      // frame 2: bit pattern and word-select
      wait_strobe();
      capture(1'b1, w, lr, b0);
      check("frame2_word", w, 32'h8001_7FFE);
      check("frame2_lrck", lr, 32'h0001_FFFE);

      // frame 4: change left one clk after the strobe
      wait_strobe();
      @(negedge clk);
      l8 = 16'hFFFF;
      capture(1'b1, w, lr, b0);
      check("latch_iso_cur", w, 32'h8001_7FFE);
      capture(1'b0, w, lr, b0);
      check("latch_iso_next", w, 32'hFFFF_7FFE);

      // frame 7 gets an odd R so the muted frame's slot 0 carries a 1
      r8 = 16'h7FFF;
      wait_strobe();
      mute8 = 1'b1;
      l8 = 16'h5555;
      r8 = 16'h5555;
      wait_strobe();
      mute8 = 1'b0;
      capture(1'b1, w, lr, b0);
      check("mute_slot0_prev_lsb", {31'd0, b0}, 32'd1);
      check("mute_frame_zero", w, 32'h0000_0000);
      capture(1'b0, w, lr, b0);
      check("unmute_next_frame", w, 32'h5555_5555);

      // reset in slot 20
      wait_strobe();
      repeat (20 * 2 * H8 + 4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midframe_rst_outputs", {24'd0, ns8, bck8, lrck8, data8, ns2, bck2, lrck2, data2}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_to_strobe(n);
      check("post_rst_strobe_edge", n, 32'd16);

      repeat (1200) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
